// File: rtl/microstate_sequencer_pkg.sv
// Shared constants for the ARM control unit: microstate codes, next-state
// select encodings and sequencing fault codes.
package microstate_sequencer_pkg;

  localparam int STATE_W = 7;

  localparam logic [2:0] NS_DISPATCH = 3'd0;
  localparam logic [2:0] NS_FETCH    = 3'd1;
  localparam logic [2:0] NS_INC      = 3'd2;
  localparam logic [2:0] NS_JUMP     = 3'd3;
  localparam logic [2:0] NS_CBR      = 3'd4;
  localparam logic [2:0] NS_WAIT     = 3'd5;
  localparam logic [2:0] NS_CALL     = 3'd6;
  localparam logic [2:0] NS_RET      = 3'd7;

  localparam logic [STATE_W-1:0] ST_RESET = 7'd0;
  localparam logic [STATE_W-1:0] ST_FETCH = 7'd1;
  localparam logic [STATE_W-1:0] ST_UNDEF = 7'd91;
  localparam logic [STATE_W-1:0] ST_FAULT = 7'd92;

  typedef enum logic [1:0] {
    FC_NONE        = 2'd0,
    FC_MOC_TIMEOUT = 2'd1,
    FC_RET_NO_CALL = 2'd2
  } fault_code_e;

endpackage

// File: rtl/microstate_sequencer_moc_wait_timer.sv
// Counts consecutive cycles spent waiting for MOC; flags the last allowed cycle.
module microstate_sequencer_moc_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic moc_i,
  output logic timeout_o
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // MOC arriving on the final cycle suppresses the timeout.
  assign timeout_o = en_i && !moc_i && (cnt_q == CW'(MAX_WAIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || moc_i || timeout_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/microstate_sequencer.sv
// Microstate next-state sequencer: dispatch, branch, one-level call/return
// and MOC wait with timeout; current microstate addresses the control store.
module microstate_sequencer
  import microstate_sequencer_pkg::*;
#(
  parameter int                   SW          = STATE_W,
  parameter logic [STATE_W-1:0]   RESET_STATE = ST_RESET,
  parameter logic [STATE_W-1:0]   FETCH_STATE = ST_FETCH,
  parameter logic [STATE_W-1:0]   UNDEF_STATE = ST_UNDEF,
  parameter logic [STATE_W-1:0]   FAULT_STATE = ST_FAULT,
  parameter int                   MAX_WAIT    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] encoder_in,
  input  logic [STATE_W-1:0] cr_in,
  input  logic [2:0]         ns_sel,
  input  logic               inv,
  input  logic               cond_in,
  input  logic               moc,
  output logic [STATE_W-1:0] state_out,
  output logic               wait_active,
  output logic               undef_dispatch,
  output logic               fault,
  output logic [1:0]         fault_code
);

  logic [STATE_W-1:0] state_q, state_d, ret_q, ret_d, inc;
  logic               ret_vld_q, ret_vld_d;
  logic               undef_q, undef_d, fault_q, fault_d;
  fault_code_e        code_q, code_d;
  logic               timeout;

  assign inc = state_q + 1'b1;

  microstate_sequencer_moc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en_i     (ns_sel == NS_WAIT),
    .moc_i    (moc),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d   = inc;
    ret_d     = ret_q;
    ret_vld_d = ret_vld_q;
    undef_d   = 1'b0;
    fault_d   = 1'b0;
    code_d    = code_q;
    case (ns_sel)
      NS_DISPATCH: begin
        state_d = encoder_in;
        undef_d = (encoder_in == UNDEF_STATE);
      end
      NS_FETCH: state_d = FETCH_STATE;
      NS_INC:   state_d = inc;
      NS_JUMP:  state_d = cr_in;
      NS_CBR:   state_d = (cond_in ^ inv) ? cr_in : inc;
      NS_WAIT: begin
        if (moc) state_d = inc;
        else if (timeout) begin
          state_d = FAULT_STATE;
          fault_d = 1'b1;
          code_d  = FC_MOC_TIMEOUT;
        end else state_d = state_q;
      end
      NS_CALL: begin
        ret_d     = inc;
        ret_vld_d = 1'b1;
        state_d   = cr_in;
      end
      NS_RET: begin
        if (ret_vld_q) begin
          state_d   = ret_q;
          ret_vld_d = 1'b0;
        end else begin
          state_d = FAULT_STATE;
          fault_d = 1'b1;
          code_d  = FC_RET_NO_CALL;
        end
      end
      default: state_d = inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      ret_q     <= '0;
      ret_vld_q <= 1'b0;
      undef_q   <= 1'b0;
      fault_q   <= 1'b0;
      code_q    <= FC_NONE;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      ret_vld_q <= ret_vld_d;
      undef_q   <= undef_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
    end
  end

  // Wait indication follows the live microinstruction fields, not a register.
  assign wait_active    = !reset && (ns_sel == NS_WAIT) && !moc;
  assign state_out      = state_q;
  assign undef_dispatch = undef_q;
  assign fault          = fault_q;
  assign fault_code     = code_q;

endmodule

// File: tb/tb_microstate_sequencer.sv
// Directed bench for microstate_sequencer: vector table plus wait/reset sequences.
module tb_microstate_sequencer;
  import microstate_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] encoder_in, cr_in, state_out;
  logic [2:0] ns_sel;
  logic       inv, cond_in, moc;
  logic       wait_active, undef_dispatch, fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  microstate_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .encoder_in    (encoder_in),
    .cr_in         (cr_in),
    .ns_sel        (ns_sel),
    .inv           (inv),
    .cond_in       (cond_in),
    .moc           (moc),
    .state_out     (state_out),
    .wait_active   (wait_active),
    .undef_dispatch(undef_dispatch),
    .fault         (fault),
    .fault_code    (fault_code)
  );

  typedef struct {
    logic [2:0] ns;
    logic [6:0] enc;
    logic [6:0] cr;
    logic       iv;
    logic       cn;
    logic [6:0] st;
    logic       und;
    logic       flt;
    logic [1:0] code;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] ns, input logic [6:0] enc, input logic [6:0] cr,
                     input logic iv, input logic cn, input logic [6:0] st,
                     input logic und, input logic flt, input logic [1:0] code);
    vec_t v;
    v.ns = ns; v.enc = enc; v.cr = cr; v.iv = iv; v.cn = cn;
    v.st = st; v.und = und; v.flt = flt; v.code = code;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ns, input logic [6:0] cr, input logic mc);
    ns_sel = ns; cr_in = cr; moc = mc; encoder_in = 7'd0; inv = 1'b0; cond_in = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic [6:0] st, input logic flt,
                           input logic [1:0] code);
    chk({nm, " state"}, state_out, st);
    chk({nm, " fault"}, fault, flt);
    chk({nm, " code"}, fault_code, code);
  endtask

  initial begin
    add(NS_FETCH,    0,   0, 0, 0, 7'd1,   0, 0, 0);
    add(NS_INC,      0,   0, 0, 0, 7'd2,   0, 0, 0);
    add(NS_INC,      0,   0, 0, 0, 7'd3,   0, 0, 0);
    add(NS_JUMP,     0, 127, 0, 0, 7'd127, 0, 0, 0);
    add(NS_INC,      0,   0, 0, 0, 7'd0,   0, 0, 0);
    add(NS_DISPATCH, 43,  0, 0, 0, 7'd43,  0, 0, 0);
    add(NS_DISPATCH, 91,  0, 0, 0, 7'd91,  1, 0, 0);
    add(NS_DISPATCH, 0,   0, 0, 0, 7'd0,   0, 0, 0);
    add(NS_JUMP,     0,  10, 0, 0, 7'd10,  0, 0, 0);
    add(NS_CBR,      0,  40, 0, 1, 7'd40,  0, 0, 0);
    add(NS_JUMP,     0,  10, 0, 0, 7'd10,  0, 0, 0);
    add(NS_CBR,      0,  40, 1, 1, 7'd11,  0, 0, 0);
    add(NS_JUMP,     0,  10, 0, 0, 7'd10,  0, 0, 0);
    add(NS_CBR,      0,  40, 1, 0, 7'd40,  0, 0, 0);
    add(NS_JUMP,     0,  10, 0, 0, 7'd10,  0, 0, 0);
    add(NS_CBR,      0,  40, 0, 0, 7'd11,  0, 0, 0);
    add(NS_JUMP,     0,  30, 0, 0, 7'd30,  0, 0, 0);
    add(NS_CALL,     0,  60, 0, 0, 7'd60,  0, 0, 0);
    add(NS_INC,      0,   0, 0, 0, 7'd61,  0, 0, 0);
    add(NS_RET,      0,   0, 0, 0, 7'd31,  0, 0, 0);
    add(NS_RET,      0,   0, 0, 0, 7'd92,  0, 1, 2);
    add(NS_INC,      0,   0, 0, 0, 7'd93,  0, 0, 2);

    reset = 1'b1;
    drive(NS_FETCH, 0, 0);
    tick;
    tick;
    chk("reset state", state_out, 0);
    chk("reset undef", undef_dispatch, 0);
    chk_state("reset", 7'd0, 0, 0);
    chk("reset wait_active", wait_active, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      ns_sel = vecs[i].ns; encoder_in = vecs[i].enc; cr_in = vecs[i].cr;
      inv = vecs[i].iv; cond_in = vecs[i].cn; moc = 1'b0;
      tick;
      chk($sformatf("vec%0d state", i), state_out, vecs[i].st);
      chk($sformatf("vec%0d undef", i), undef_dispatch, vecs[i].und);
      chk($sformatf("vec%0d fault", i), fault, vecs[i].flt);
      chk($sformatf("vec%0d code", i), fault_code, vecs[i].code);
    end

    // MOC after five held cycles
    drive(NS_JUMP, 20, 0); tick;
    for (int k = 0; k < 5; k++) begin
      drive(NS_WAIT, 0, 0); #1;
      chk($sformatf("waitA%0d active", k), wait_active, 1);
      tick;
      chk_state($sformatf("waitA%0d", k), 7'd20, 0, 2);
    end
    drive(NS_WAIT, 0, 1); #1;
    chk("waitA moc active", wait_active, 0);
    tick;
    chk_state("waitA done", 7'd21, 0, 2);

    // MOC never arrives: fault on the 16th cycle
    drive(NS_JUMP, 20, 0); tick;
    for (int k = 0; k < 15; k++) begin
      drive(NS_WAIT, 0, 0); tick;
      chk_state($sformatf("waitB%0d", k), 7'd20, 0, 2);
    end
    drive(NS_WAIT, 0, 0); tick;
    chk_state("waitB timeout", 7'd92, 1, 1);
    drive(NS_INC, 0, 0); tick;
    chk_state("waitB after", 7'd93, 0, 1);

    // MOC on the final allowed cycle beats the timeout
    drive(NS_JUMP, 20, 0); tick;
    for (int k = 0; k < 15; k++) begin
      drive(NS_WAIT, 0, 0); tick;
    end
    chk_state("waitC held", 7'd20, 0, 1);
    drive(NS_WAIT, 0, 1); tick;
    chk_state("waitC moc", 7'd21, 0, 1);

    // Reset mid-wait with a pending return address
    drive(NS_JUMP, 30, 0); tick;
    drive(NS_CALL, 60, 0); tick;
    drive(NS_JUMP, 20, 0); tick;
    for (int k = 0; k < 8; k++) begin
      drive(NS_WAIT, 0, 0); tick;
    end
    chk_state("rst pre", 7'd20, 0, 1);
    reset = 1'b1; #1;
    chk("rst wait_active", wait_active, 0);
    tick;
    chk_state("rst", 7'd0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      drive(NS_WAIT, 0, 0); tick;
    end
    chk_state("rst cnt cleared", 7'd0, 0, 0);
    drive(NS_WAIT, 0, 0); tick;
    chk_state("rst timeout", 7'd92, 1, 1);
    drive(NS_RET, 0, 0); tick;
    chk_state("rst ret", 7'd92, 1, 2);
    drive(NS_FETCH, 0, 0); tick;
    chk_state("rst final", 7'd1, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/microstate_sequencer.md
Name: microstate_sequencer

Overview:
- Next-state sequencer for the ARM control unit. It consumes the 7-bit dispatch state produced by the instruction encoder and the sequencing fields of the current microinstruction.
- It registers the current microstate, which addresses the control-store ROM.
- It provides increment, jump, conditional branch, a one-level micro-subroutine, and memory-wait hold with timeout.
- It flags dispatch to the undefined-instruction state and sequencing faults.

Parameters:
STATE_W, 7, microstate width (matches encoder output)
RESET_STATE, 7'd0, state after reset
FETCH_STATE, 7'd1, first fetch microstate
UNDEF_STATE, 7'd91, encoder code for unrecognised instruction
FAULT_STATE, 7'd92, state entered on sequencing fault
MAX_WAIT, 16, max cycles held waiting for MOC before fault

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
encoder_in  input  7  dispatch state from instruction encoder
cr_in  input  7  branch target field of current microinstruction
ns_sel  input  3  next-state select field of current microinstruction
inv  input  1  invert condition for conditional branch
cond_in  input  1  condition result (flags tester)
moc  input  1  memory operation complete
state_out  output  7  current microstate (registered), ROM address
wait_active  output  1  high while holding in a WAIT_MOC state
undef_dispatch  output  1  one-cycle pulse: dispatch loaded UNDEF_STATE
fault  output  1  one-cycle pulse on any sequencing fault
fault_code  output  2  0 none, 1 MOC timeout, 2 RET without CALL; held until next fault or reset

Behaviour:
- All state updates occur on the rising edge of clk.
- Reset: if reset=1 at an edge, state_out=RESET_STATE, ret_reg=0, ret_valid=0, wait_cnt=0, wait_active=0, undef_dispatch=0, fault=0, fault_code=0. Reset overrides all other inputs, including a wait or call in progress.
- inc = state_out+1, mod 128, so 127 wraps to 0.
- Next state is decided by ns_sel, latency one cycle:
  - 0 DISPATCH: next=encoder_in, taken as-is. Encoder value 0 (all-zero IR) goes to state 0. If encoder_in==UNDEF_STATE, undef_dispatch=1 next cycle.
  - 1 FETCH: next=FETCH_STATE.
  - 2 INC: next=inc.
  - 3 JUMP: next=cr_in.
  - 4 CBR: next = (cond_in^inv) ? cr_in : inc.
  - 5 WAIT_MOC:
    - moc=1: next=inc, wait_cnt cleared.
    - else if wait_cnt==MAX_WAIT-1: next=FAULT_STATE, fault pulse, fault_code=1, wait_cnt cleared.
    - else: hold state_out, wait_cnt+1.
    - wait_active = (ns_sel==5 && !moc), combinational from the registered state's fields.
    - moc and timeout in the same cycle: moc wins.
  - 6 CALL: ret_reg=inc, ret_valid=1, next=cr_in. CALL while ret_valid=1 overwrites ret_reg (single level, no nesting).
  - 7 RET:
    - ret_valid=1: next=ret_reg, ret_valid=0.
    - else: next=FAULT_STATE, fault pulse, fault_code=2.
- wait_cnt is cleared whenever ns_sel!=5.
- fault and undef_dispatch are registered pulses, exactly one cycle wide.
- A sequence of consecutive DISPATCH cycles is legal; each cycle re-samples encoder_in.

Decomposition:
- Shared package (control_pkg):
  - ns_sel codes: NS_DISPATCH..NS_RET.
  - State constants: RESET, FETCH, UNDEF=91, FAULT=92. The encoder also uses these.
  - fault_code enumeration.
- One sub-module, moc_wait_timer: counter with clear/enable/moc inputs and a timeout output. Width is clog2(MAX_WAIT).
- The rest is flat: next-state mux, return register, output registers.

Test Plan:
- Reset then ns_sel=1 -> state_out 0, then 1. Next INC cycles -> 2, 3. Force state 127 via JUMP cr_in=127, then INC -> 0 (wrap).
- DISPATCH with encoder_in=7'b0101011 (43) -> state_out=43 next cycle, undef_dispatch=0. Then encoder_in=91 -> state 91, undef_dispatch pulses exactly one cycle.
- CBR with cr_in=40 at state 10:
  - cond_in=1, inv=0 -> 40.
  - cond_in=1, inv=1 -> 11.
  - cond_in=0, inv=1 -> 40.
- WAIT_MOC at state 20:
  - moc rises after 5 cycles -> wait_active high 5 cycles, state held at 20, then 21.
  - moc never rises -> after 16 cycles state=92, fault pulse, fault_code=1.
  - moc=1 on cycle 16 -> 21, no fault.
- CALL at state 30 with cr_in=60 -> 60. INC -> 61. RET -> 31. Second RET -> 92, fault_code=2.
- Reset asserted mid-wait (cycle 8) and with ret_valid=1 -> state 0, wait_cnt 0. A following RET faults with code 2.
